prog_loader: RTL
================

Name: prog_loader

Overview:
- Boot-time sequencer for the onc_16 core.
- Holds the CPU in reset and accepts a framed byte stream from a host link (UART receiver or debug bridge).
- Assembles the bytes into instruction words and writes them into instruction memory from address 0.
- Checks a frame checksum, then releases the CPU; a reload request re-enters loading at any time.

Parameters:
- INST_W, 16, instruction word width; must equal `INST_W.
- ADDR_W, 16, instruction memory write-address width.
- DEPTH, 256, number of instruction memory words; the highest legal word count.

Ports:
- clock  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  8  incoming frame byte.
- rx_valid  in  1  rx_data is valid this cycle.
- rx_ready  out  1  loader accepts a byte this cycle; a transfer happens when rx_valid and rx_ready are both high.
- load_req  in  1  single-cycle pulse; abort or finish the current state and restart loading.
- imem_we  out  1  instruction memory write strobe.
- imem_waddr  out  ADDR_W  write word address.
- imem_wdata  out  INST_W  write word.
- cpu_n_rst  out  1  active-low reset to onc_16 (its n_rst).
- busy  out  1  loader is in a loading state.
- done  out  1  last load succeeded and the CPU is running.
- err  out  1  last load failed.

Behaviour:
- Frame format (all multi-byte fields big-endian):
  - CNT_H, CNT_L: 16-bit word count N.
  - N × (word high byte, word low byte).
  - CHK: one checksum byte, chosen so the mod-256 sum of every frame byte, including CHK, is 0x00.
- State machine: S_CNT_H, S_CNT_L, S_DAT_H, S_DAT_L, S_CHK, S_RUN, S_ERR.
- On reset:
  - state = S_CNT_H.
  - imem_we = 0, imem_waddr = 0, imem_wdata = 0.
  - cpu_n_rst = 0, done = 0, err = 0.
  - Checksum accumulator = 0, word counter = 0.
- rx_ready is high in S_CNT_H through S_CHK and low in S_RUN and S_ERR. It is a combinational decode of the state register only, never of rx_valid.
- Each accepted byte is added into the 8-bit checksum accumulator (wrap-around).
- Transitions, each on an accepted byte:
  - CNT_H → CNT_L; latches N[15:8].
  - CNT_L: if N > DEPTH → S_ERR. If N == 0 → S_CHK. Otherwise → S_DAT_H.
  - DAT_H → DAT_L; latches the high byte.
  - DAT_L → registers the word; → S_DAT_H if more words remain, else → S_CHK.
  - CHK → S_RUN if the final sum == 0, else → S_ERR.
- Write timing:
  - imem_we pulses for exactly one cycle, the cycle after the DAT_L byte is accepted.
  - imem_waddr / imem_wdata hold the word index and the {hi, lo} word during that cycle.
  - Addresses run 0..N-1 with no wrap, which the DEPTH check guarantees.
  - imem_we is 0 at all other times.
- Outputs are all registered and follow the state register:
  - cpu_n_rst = 1 only while state == S_RUN.
  - done = 1 only in S_RUN.
  - err = 1 only in S_ERR.
  - busy = 1 in the five loading states.
- load_req in any state, at the next edge:
  - state ← S_CNT_H; accumulator, counter and N are cleared.
  - cpu_n_rst ← 0, done ← 0, err ← 0, imem_we ← 0.
  - A byte handshaken in the same cycle is discarded.
  - load_req has priority over all byte handling.
- rx_valid gaps are allowed in any state; the state holds and nothing is written.
- rst mid-load aborts immediately (asynchronous) to the reset values. Partially written memory is not erased; the CPU stays in reset.
- After S_RUN or S_ERR, no rx bytes are consumed until load_req.

Decomposition:
- Shared constants in def.v:
  - LDR_STATE_W and the seven state encodings.
  - LDR_BYTE_W = 8.
  - LDR_CHK_OK = 8'h00.
- No sub-module. The checksum adder and byte assembler are a few lines each and stay inline in prog_loader.

Test Plan:
- Good frame: bytes 00 02 12 34 AB CD 40, rx_valid held high → two imem_we pulses (addr 0 = 0x1234, addr 1 = 0xABCD); then cpu_n_rst = 1, done = 1, rx_ready = 0.
- Bad checksum: same frame with last byte 41 → no change to the two writes; then err = 1, cpu_n_rst stays 0, done = 0, rx_ready = 0.
- Empty frame: 00 00 00 → no imem_we; done = 1 and cpu_n_rst = 1 after the third byte is accepted.
- Overflow (DEPTH = 256): 01 01 → err = 1 immediately after the second byte; no imem_we ever asserted.
- Abort and restart: send 00 02 12, pulse load_req together with a 34 byte → 34 is ignored. Then send the good frame with rx_valid toggling every other cycle → writes restart at addr 0 and end with done = 1.
- Reset and reload:
  - Assert rst during S_DAT_L → all outputs return to their reset values asynchronously.
  - Release rst, send the good frame → done = 1.
  - Pulse load_req from S_RUN → cpu_n_rst = 0 the next cycle and rx_ready = 1.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared encodings and widths for the boot-time program loader.
// The state enum and byte/checksum constants are imported by prog_loader.
package prog_loader_pkg;

    localparam int LDR_STATE_W = 3;
    localparam int LDR_BYTE_W  = 8;
    localparam int LDR_CNT_W   = 16;
    localparam logic [LDR_BYTE_W-1:0] LDR_CHK_OK = 8'h00;

    typedef enum logic [LDR_STATE_W-1:0] {
        S_CNT_H = 3'd0,
        S_CNT_L = 3'd1,
        S_DAT_H = 3'd2,
        S_DAT_L = 3'd3,
        S_CHK   = 3'd4,
        S_RUN   = 3'd5,
        S_ERR   = 3'd6
    } ldr_state_e;

    function automatic logic is_loading(input ldr_state_e s);
        return (s != S_RUN) && (s != S_ERR);
    endfunction

endpackage

// File: rtl/prog_loader.sv
// Holds the core in reset while a framed byte stream (count, words, checksum)
// is written into instruction memory, then releases it on a good checksum.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int INST_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 256
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic [LDR_BYTE_W-1:0] rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    input  logic                  load_req,
    output logic                  imem_we,
    output logic [ADDR_W-1:0]     imem_waddr,
    output logic [INST_W-1:0]     imem_wdata,
    output logic                  cpu_n_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam logic [LDR_CNT_W-1:0] DEPTH_LIM = LDR_CNT_W'(DEPTH);

    ldr_state_e state_q, state_d;

    logic [LDR_CNT_W-1:0]  n_q, n_d;
    logic [LDR_CNT_W-1:0]  cnt_q, cnt_d;
    logic [LDR_BYTE_W-1:0] acc_q, acc_d;
    logic [LDR_BYTE_W-1:0] hi_q, hi_d;
    logic                  imem_we_q, imem_we_d;
    logic [ADDR_W-1:0]     waddr_q, waddr_d;
    logic [INST_W-1:0]     wdata_q, wdata_d;
    logic                  cpu_n_rst_q, cpu_n_rst_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  busy_q, busy_d;

    logic                  accept;
    logic [LDR_BYTE_W-1:0] acc_sum;
    logic [LDR_CNT_W-1:0]  n_full;
    logic [LDR_CNT_W-1:0]  cnt_inc;

    assign rx_ready = is_loading(state_q);
    assign accept   = rx_valid && rx_ready;
    assign acc_sum  = acc_q + rx_data;
    assign n_full   = {n_q[LDR_CNT_W-1:LDR_BYTE_W], rx_data};
    assign cnt_inc  = cnt_q + 1'b1;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q <= S_CNT_H;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (load_req) begin
            state_d = S_CNT_H;
        end else if (accept) begin
            case (state_q)
                S_CNT_H: state_d = S_CNT_L;
                S_CNT_L: begin
                    if (n_full > DEPTH_LIM)
                        state_d = S_ERR;
                    else if (n_full == '0)
                        state_d = S_CHK;
                    else
                        state_d = S_DAT_H;
                end
                S_DAT_H: state_d = S_DAT_L;
                S_DAT_L: state_d = (cnt_inc < n_q) ? S_DAT_H : S_CHK;
                S_CHK:   state_d = (acc_sum == LDR_CHK_OK) ? S_RUN : S_ERR;
                default: state_d = state_q;
            endcase
        end
    end

    // Datapath and status next values; status flags are registered from
    // state_d so they line up exactly with the state register.
    always_comb begin
        n_d         = n_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        hi_d        = hi_q;
        imem_we_d   = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        if (load_req) begin
            n_d   = '0;
            cnt_d = '0;
            acc_d = '0;
        end else if (accept) begin
            acc_d = acc_sum;
            case (state_q)
                S_CNT_H: n_d = {rx_data, {LDR_BYTE_W{1'b0}}};
                S_CNT_L: n_d = n_full;
                S_DAT_H: hi_d = rx_data;
                S_DAT_L: begin
                    imem_we_d = 1'b1;
                    waddr_d   = ADDR_W'(cnt_q);
                    wdata_d   = INST_W'({hi_q, rx_data});
                    cnt_d     = cnt_inc;
                end
                default: ;
            endcase
        end
        cpu_n_rst_d = (state_d == S_RUN);
        done_d      = (state_d == S_RUN);
        err_d       = (state_d == S_ERR);
        busy_d      = is_loading(state_d);
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            n_q         <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            hi_q        <= '0;
            imem_we_q   <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            cpu_n_rst_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            n_q         <= n_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            hi_q        <= hi_d;
            imem_we_q   <= imem_we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            cpu_n_rst_q <= cpu_n_rst_d;
            done_q      <= done_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_waddr = waddr_q;
    assign imem_wdata = wdata_q;
    assign cpu_n_rst  = cpu_n_rst_q;
    assign done       = done_q;
    assign err        = err_q;
    assign busy       = busy_q;

endmodule
